id_stage_hs: RTL and testbench

- Next-generation instruction-decode / operand-fetch stage, between IF and EX.
- Parametrised in data width and register-address width.
- Valid/ready handshakes on both sides replace the implicit stall.
- Explicit FSM tolerates variable-latency register-file reads; registered outputs; synchronous flush; sticky HALT detection.

---
 rtl/id_stage_hs_pkg.sv | 73 +++++++
 rtl/id_stage_hs_if.sv | 55 +++++
 rtl/id_stage_hs_decode.sv | 58 +++++
 rtl/id_stage_hs.sv | 219 +++++++++++++++++++++
 tb/tb_id_stage_hs.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_hs_pkg.sv
// Shared constants, field positions, opcode map and types for the id_stage_hs decode stage.
package id_stage_hs_pkg;

    localparam int unsigned WIDTH_DEF        = 32;
    localparam int unsigned REG_ADDR_LEN_DEF = 5;
    localparam logic [WIDTH_DEF-1:0] NOP_WORD = '0;

    // Instruction field positions; bits above 31 carry no fields.
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned FLD_W   = 5;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS_MSB  = 20;
    localparam int unsigned RS_LSB  = 16;
    localparam int unsigned RT_MSB  = 15;
    localparam int unsigned RT_LSB  = 11;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned TGT_W   = 26;
    localparam int unsigned TGT_MSB = 25;
    localparam int unsigned TGT_LSB = 0;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_NOP    = 6'h00;
    localparam opcode_t OP_R_TYPE = 6'h01;
    localparam opcode_t OP_I_TYPE = 6'h02;
    localparam opcode_t OP_LW     = 6'h03;
    localparam opcode_t OP_LH     = 6'h04;
    localparam opcode_t OP_LD     = 6'h05;
    localparam opcode_t OP_BRANCH = 6'h06;
    localparam opcode_t OP_SD     = 6'h07;
    localparam opcode_t OP_SH     = 6'h08;
    localparam opcode_t OP_SW     = 6'h09;
    localparam opcode_t OP_J_TYPE = 6'h0A;
    localparam opcode_t OP_HALT   = 6'h3F;

    typedef enum logic [1:0] {
        SRC_REG      = 2'd0,
        SRC_SEXT_IMM = 2'd1,
        SRC_ZEXT_TGT = 2'd2,
        SRC_ZERO     = 2'd3
    } opnd_src_e;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_RD   = 2'd1,
        FLD_RS   = 2'd2,
        FLD_RT   = 2'd3
    } fld_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    // Decoder result: which read ports are needed, where their addresses come from,
    // and how X/Y are formed.
    typedef struct packed {
        logic      need1;
        logic      need2;
        fld_sel_e  p1_sel;
        fld_sel_e  p2_sel;
        opnd_src_e x_src;
        opnd_src_e y_src;
        logic      is_halt;
    } dec_t;

endpackage

// File: rtl/id_stage_hs_if.sv
// IF/EX handshake, register-file read ports and flush/halt signals of id_stage_hs.
// ID_BYPASS_EN adds the write-back bypass inputs wb_en/wb_addr/wb_data.
interface id_stage_hs_if #(
    parameter int unsigned WIDTH        = id_stage_hs_pkg::WIDTH_DEF,
    parameter int unsigned REG_ADDR_LEN = id_stage_hs_pkg::REG_ADDR_LEN_DEF
);
    localparam int unsigned PC_W = WIDTH - 2;

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        ir_in;
    logic [PC_W-1:0]         pc_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        ir_out;
    logic [PC_W-1:0]         pc_out;
    logic [WIDTH-1:0]        x_out;
    logic [WIDTH-1:0]        y_out;
    logic [REG_ADDR_LEN-1:0] rd1_addr;
    logic                    rd1_en;
    logic [WIDTH-1:0]        rd1_data;
    logic                    rd1_st;
    logic [REG_ADDR_LEN-1:0] rd2_addr;
    logic                    rd2_en;
    logic [WIDTH-1:0]        rd2_data;
    logic                    rd2_st;
    logic                    is_flush;
    logic                    halted;
`ifdef ID_BYPASS_EN
    logic                    wb_en;
    logic [REG_ADDR_LEN-1:0] wb_addr;
    logic [WIDTH-1:0]        wb_data;
`endif

    modport master (
        input  in_valid, ir_in, pc_in, out_ready,
        input  rd1_data, rd1_st, rd2_data, rd2_st, is_flush,
`ifdef ID_BYPASS_EN
        input  wb_en, wb_addr, wb_data,
`endif
        output in_ready, out_valid, ir_out, pc_out, x_out, y_out,
        output rd1_addr, rd1_en, rd2_addr, rd2_en, halted
    );

    modport slave (
        output in_valid, ir_in, pc_in, out_ready,
        output rd1_data, rd1_st, rd2_data, rd2_st, is_flush,
`ifdef ID_BYPASS_EN
        output wb_en, wb_addr, wb_data,
`endif
        input  in_ready, out_valid, ir_out, pc_out, x_out, y_out,
        input  rd1_addr, rd1_en, rd2_addr, rd2_en, halted
    );

endinterface

// File: rtl/id_stage_hs_decode.sv
// Combinational opcode decoder: read-port needs, address field selects, operand sources, HALT flag.
module id_decode
    import id_stage_hs_pkg::*;
(
    input  opcode_t opcode,
    output dec_t    dec
);

    always_comb begin
        dec.need1   = 1'b0;
        dec.need2   = 1'b0;
        dec.p1_sel  = FLD_NONE;
        dec.p2_sel  = FLD_NONE;
        dec.x_src   = SRC_ZERO;
        dec.y_src   = SRC_ZERO;
        dec.is_halt = 1'b0;
        case (opcode)
            OP_R_TYPE: begin
                dec.need1  = 1'b1;
                dec.need2  = 1'b1;
                dec.p1_sel = FLD_RS;
                dec.p2_sel = FLD_RT;
                dec.x_src  = SRC_REG;
                dec.y_src  = SRC_REG;
            end
            OP_I_TYPE, OP_LW, OP_LH, OP_LD: begin
                dec.need1  = 1'b1;
                dec.p1_sel = FLD_RS;
                dec.x_src  = SRC_REG;
                dec.y_src  = SRC_SEXT_IMM;
            end
            OP_BRANCH: begin
                dec.need1  = 1'b1;
                dec.p1_sel = FLD_RD;
                dec.x_src  = SRC_REG;
                dec.y_src  = SRC_SEXT_IMM;
            end
            OP_SD, OP_SH, OP_SW: begin
                dec.need1  = 1'b1;
                dec.need2  = 1'b1;
                dec.p1_sel = FLD_RD;
                dec.p2_sel = FLD_RS;
                dec.x_src  = SRC_REG;
                dec.y_src  = SRC_REG;
            end
            OP_J_TYPE: begin
                dec.x_src  = SRC_ZEXT_TGT;
                dec.y_src  = SRC_ZERO;
            end
            OP_HALT: begin
                dec.is_halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/id_stage_hs.sv
// Decode / operand-fetch stage with valid/ready on both sides and variable-latency register reads.
// Optional macro ID_BYPASS_EN enables the write-back bypass into operand capture.
module id_stage_hs
    import id_stage_hs_pkg::*;
#(
    parameter int unsigned WIDTH        = WIDTH_DEF,
    parameter int unsigned REG_ADDR_LEN = REG_ADDR_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    id_stage_hs_if.master bus
);

    localparam int unsigned PC_W = WIDTH - 2;
    localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_WORD);

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        ir_q, ir_d;
    logic [PC_W-1:0]         pc_q, pc_d;
    logic [WIDTH-1:0]        x_q, x_d;
    logic [WIDTH-1:0]        y_q, y_d;
    logic [REG_ADDR_LEN-1:0] a1_q, a1_d, a2_q, a2_d;
    logic                    en1_q, en1_d, en2_q, en2_d;
    logic                    hb_q, hb_d;
    logic                    halted_q, halted_d;

    opcode_t                 opc_in;
    dec_t                    dec_in;
    logic [FLD_W-1:0]        f_rd, f_rs, f_rt;
    logic [IMM_W-1:0]        f_imm;
    logic [TGT_W-1:0]        f_tgt;
    logic [WIDTH-1:0]        sext_imm, zext_tgt;
    logic [REG_ADDR_LEN-1:0] p1_addr, p2_addr;

    logic                    in_ready, accept, out_hs;
    logic                    pend1, pend2, take1, take2;
    logic [WIDTH-1:0]        data1, data2, wb_data;
    logic                    byp1_acc, byp2_acc, byp1_wait, byp2_wait;

    function automatic logic [REG_ADDR_LEN-1:0] sel_addr(
        input fld_sel_e         sel,
        input logic [FLD_W-1:0] rd,
        input logic [FLD_W-1:0] rs,
        input logic [FLD_W-1:0] rt
    );
        case (sel)
            FLD_RD:  return REG_ADDR_LEN'(rd);
            FLD_RS:  return REG_ADDR_LEN'(rs);
            FLD_RT:  return REG_ADDR_LEN'(rt);
            default: return '0;
        endcase
    endfunction

    // Decode of the instruction presented by IF.
    assign opc_in   = bus.ir_in[OPC_MSB:OPC_LSB];
    assign f_rd     = bus.ir_in[RD_MSB:RD_LSB];
    assign f_rs     = bus.ir_in[RS_MSB:RS_LSB];
    assign f_rt     = bus.ir_in[RT_MSB:RT_LSB];
    assign f_imm    = bus.ir_in[IMM_MSB:IMM_LSB];
    assign f_tgt    = bus.ir_in[TGT_MSB:TGT_LSB];
    assign sext_imm = {{(WIDTH-IMM_W){f_imm[IMM_W-1]}}, f_imm};
    assign zext_tgt = WIDTH'(f_tgt);

    id_decode u_decode (
        .opcode (opc_in),
        .dec    (dec_in)
    );

    assign p1_addr = sel_addr(dec_in.p1_sel, f_rd, f_rs, f_rt);
    assign p2_addr = sel_addr(dec_in.p2_sel, f_rd, f_rs, f_rt);

`ifdef ID_BYPASS_EN
    assign wb_data   = bus.wb_data;
    assign byp1_acc  = bus.wb_en && (p1_addr == bus.wb_addr);
    assign byp2_acc  = bus.wb_en && (p2_addr == bus.wb_addr);
    assign byp1_wait = bus.wb_en && (a1_q == bus.wb_addr);
    assign byp2_wait = bus.wb_en && (a2_q == bus.wb_addr);
`else
    assign wb_data   = '0;
    assign byp1_acc  = 1'b0;
    assign byp2_acc  = 1'b0;
    assign byp1_wait = 1'b0;
    assign byp2_wait = 1'b0;
`endif

    // Acceptance blocked during reset, flush and after HALT has left the stage.
    assign in_ready = rst_n && !halted_q && !bus.is_flush
                   && ((state_q == ST_IDLE) || ((state_q == ST_FULL) && bus.out_ready));
    assign accept   = in_ready && bus.in_valid;
    assign out_hs   = (state_q == ST_FULL) && bus.out_ready && !bus.is_flush;

    // Reads still outstanding after accept; a bypass hit satisfies the port immediately.
    assign pend1 = dec_in.need1 && !byp1_acc;
    assign pend2 = dec_in.need2 && !byp2_acc;

    // Capture in WAIT; a coincident bypass beats the register-file strobe.
    assign take1 = (state_q == ST_WAIT) && en1_q && (byp1_wait || bus.rd1_st);
    assign take2 = (state_q == ST_WAIT) && en2_q && (byp2_wait || bus.rd2_st);
    assign data1 = byp1_wait ? wb_data : bus.rd1_data;
    assign data2 = byp2_wait ? wb_data : bus.rd2_data;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = (pend1 || pend2) ? ST_WAIT : ST_FULL;
            end
            ST_WAIT: begin
                if ((!en1_q || take1) && (!en2_q || take2)) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (bus.out_ready) begin
                    if (accept) state_d = (pend1 || pend2) ? ST_WAIT : ST_FULL;
                    else        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.is_flush) state_d = ST_IDLE;
    end

    always_comb begin
        ir_d     = ir_q;
        pc_d     = pc_q;
        x_d      = x_q;
        y_d      = y_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        en1_d    = en1_q;
        en2_d    = en2_q;
        hb_d     = hb_q;
        halted_d = halted_q || (out_hs && hb_q);

        if (take1) begin
            x_d   = data1;
            en1_d = 1'b0;
        end
        if (take2) begin
            y_d   = data2;
            en2_d = 1'b0;
        end

        if (accept) begin
            ir_d  = bus.ir_in;
            pc_d  = bus.pc_in;
            a1_d  = p1_addr;
            a2_d  = p2_addr;
            en1_d = pend1;
            en2_d = pend2;
            hb_d  = dec_in.is_halt;
            case (dec_in.x_src)
                SRC_REG:      x_d = byp1_acc ? wb_data : '0;
                SRC_SEXT_IMM: x_d = sext_imm;
                SRC_ZEXT_TGT: x_d = zext_tgt;
                default:      x_d = '0;
            endcase
            case (dec_in.y_src)
                SRC_REG:      y_d = byp2_acc ? wb_data : '0;
                SRC_SEXT_IMM: y_d = sext_imm;
                SRC_ZEXT_TGT: y_d = zext_tgt;
                default:      y_d = '0;
            endcase
        end

        if (bus.is_flush) begin
            ir_d  = NOP;
            pc_d  = '0;
            x_d   = '0;
            y_d   = '0;
            en1_d = 1'b0;
            en2_d = 1'b0;
            hb_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q     <= NOP;
            pc_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            en1_q    <= 1'b0;
            en2_q    <= 1'b0;
            hb_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            en1_q    <= en1_d;
            en2_q    <= en2_d;
            hb_q     <= hb_d;
            halted_q <= halted_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.ir_out    = ir_q;
    assign bus.pc_out    = pc_q;
    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
    assign bus.rd1_addr  = a1_q;
    assign bus.rd1_en    = en1_q;
    assign bus.rd2_addr  = a2_q;
    assign bus.rd2_en    = en2_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// Scoreboard bench for id_stage_hs; define ID_BYPASS_EN to also exercise the write-back bypass.
module tb_id_stage_hs;
    import id_stage_hs_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned PW = W - 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_stage_hs_if #(.WIDTH(W), .REG_ADDR_LEN(AW)) bus ();
    id_stage_hs #(.WIDTH(W), .REG_ADDR_LEN(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [W-1:0]  ir;
        logic [PW-1:0] pc;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] ir, input logic [PW-1:0] pc,
                        input logic [W-1:0] x, input logic [W-1:0] y);
        exp_q.push_back('{ir: ir, pc: pc, x: x, y: y});
    endtask

    // Every bundle handed to EX must match the oldest expected bundle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got ir=%h pc=%h with no bundle expected", bus.ir_out, bus.pc_out);
            end else begin
                sb_e = exp_q.pop_front();
                if ({bus.ir_out, bus.pc_out, bus.x_out, bus.y_out} !== sb_e) begin
                    errors++;
                    $display("FAIL sb_bundle: got ir=%h pc=%h x=%h y=%h, want ir=%h pc=%h x=%h y=%h",
                             bus.ir_out, bus.pc_out, bus.x_out, bus.y_out, sb_e.ir, sb_e.pc, sb_e.x, sb_e.y);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.out_valid, bus.ir_out, bus.pc_out, bus.x_out, bus.y_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b ir=%h pc=%h x=%h y=%h, want all zero",
                     bus.out_valid, bus.ir_out, bus.pc_out, bus.x_out, bus.y_out);
        end
        checks++;
        if ({bus.rd1_addr, bus.rd1_en, bus.rd2_addr, bus.rd2_en, bus.halted} !== '0) begin
            errors++;
            $display("FAIL reset_rdports: got a1=%h e1=%b a2=%h e2=%b halted=%b, want 0",
                     bus.rd1_addr, bus.rd1_en, bus.rd2_addr, bus.rd2_en, bus.halted);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_low: got %b want 0", bus.in_ready);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_after: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_r_type();
        logic [31:0] ir;
        ir = enc_r(OP_R_TYPE, 5'd1, 5'd3, 5'd4);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.ir_in     = ir;
        bus.pc_in     = PW'(32'h100);
        push(ir, PW'(32'h100), 32'h11, 32'h22);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.rd1_en, bus.rd2_en, bus.rd1_addr, bus.rd2_addr} !== {1'b0, 1'b1, 1'b1, 5'd3, 5'd4}) begin
            errors++;
            $display("FAIL rtype_reads: got v=%b e1=%b e2=%b a1=%0d a2=%0d, want v=0 e1=1 e2=1 a1=3 a2=4",
                     bus.out_valid, bus.rd1_en, bus.rd2_en, bus.rd1_addr, bus.rd2_addr);
        end
        bus.rd1_st = 1'b1; bus.rd1_data = 32'h11;
        tick();
        bus.rd1_st = 1'b0; bus.rd1_data = '0;
        checks++;
        if ({bus.out_valid, bus.rd1_en, bus.rd2_en} !== 3'b001) begin
            errors++;
            $display("FAIL rtype_plus2: got v=%b e1=%b e2=%b, want 0 0 1", bus.out_valid, bus.rd1_en, bus.rd2_en);
        end
        tick();
        bus.rd2_st = 1'b1; bus.rd2_data = 32'h22;
        bus.rd1_st = 1'b1; bus.rd1_data = 32'hDEAD;
        checks++;
        if ({bus.out_valid, bus.rd2_en} !== 2'b01) begin
            errors++;
            $display("FAIL rtype_plus3: got v=%b e2=%b, want 0 1", bus.out_valid, bus.rd2_en);
        end
        tick();
        bus.rd2_st = 1'b0; bus.rd1_st = 1'b0;
        checks++;
        if ({bus.out_valid, bus.rd2_en, bus.x_out, bus.y_out} !== {1'b1, 1'b0, 32'h11, 32'h22}) begin
            errors++;
            $display("FAIL rtype_plus4: got v=%b e2=%b x=%h y=%h, want v=1 e2=0 x=11 y=22",
                     bus.out_valid, bus.rd2_en, bus.x_out, bus.y_out);
        end
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rtype_drain: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_i_type();
        logic [31:0] ir;
        ir = enc_i(OP_I_TYPE, 5'd1, 5'd2, 16'hFFF0);
        bus.in_valid = 1'b1;
        bus.ir_in    = ir;
        bus.pc_in    = PW'(32'h200);
        push(ir, PW'(32'h200), 32'h5, 32'hFFFF_FFF0);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.rd1_en, bus.rd2_en, bus.rd1_addr} !== {1'b1, 1'b0, 5'd2}) begin
            errors++;
            $display("FAIL itype_reads: got e1=%b e2=%b a1=%0d, want 1 0 2", bus.rd1_en, bus.rd2_en, bus.rd1_addr);
        end
        bus.rd1_st = 1'b1; bus.rd1_data = 32'h5;
        bus.rd2_st = 1'b1; bus.rd2_data = 32'hBAD0;
        tick();
        bus.rd1_st = 1'b0; bus.rd2_st = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if ({bus.out_valid, bus.rd2_en, bus.x_out, bus.y_out} !== {1'b1, 1'b0, 32'h5, 32'hFFFF_FFF0}) begin
            errors++;
            $display("FAIL itype_result: got v=%b e2=%b x=%h y=%h, want v=1 e2=0 x=5 y=fffffff0",
                     bus.out_valid, bus.rd2_en, bus.x_out, bus.y_out);
        end
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_j_type();
        logic [31:0] ir_j, ir_u;
        ir_j = enc_j(OP_J_TYPE, 26'h0123456);
        ir_u = enc_j(6'h2A, 26'h0000155);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ir_in     = ir_j;
        bus.pc_in     = PW'(32'h300);
        push(ir_j, PW'(32'h300), 32'h0012_3456, 32'h0);
        tick();
        bus.ir_in = ir_u;
        bus.pc_in = PW'(32'h301);
        push(ir_u, PW'(32'h301), 32'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.ir_out, bus.x_out, bus.y_out} !== {1'b1, 1'b0, ir_j, 32'h0012_3456, 32'h0}) begin
                errors++;
                $display("FAIL jtype_hold%0d: got v=%b rdy=%b ir=%h x=%h y=%h, want v=1 rdy=0 ir=%h x=00123456 y=0",
                         k, bus.out_valid, bus.in_ready, bus.ir_out, bus.x_out, bus.y_out, ir_j);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL jtype_b2b_ready: got v=%b rdy=%b want 1 1", bus.out_valid, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.ir_out, bus.x_out, bus.y_out} !== {1'b1, ir_u, 64'h0}) begin
            errors++;
            $display("FAIL unknown_passthru: got v=%b ir=%h x=%h y=%h, want v=1 ir=%h x=0 y=0",
                     bus.out_valid, bus.ir_out, bus.x_out, bus.y_out, ir_u);
        end
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL jtype_drain: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ir;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ir = enc_j(OP_J_TYPE, 26'(i * 32'h111 + 1));
            bus.in_valid = 1'b1;
            bus.ir_in    = ir;
            bus.pc_in    = PW'(32'h600 + i);
            push(ir, PW'(32'h600 + i), 32'(i * 32'h111 + 1), 32'h0);
            #1;
            checks++;
            if ({bus.in_ready, bus.out_valid} !== {1'b1, (i > 0)}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got rdy=%b v=%b want rdy=1 v=%b", i, bus.in_ready, bus.out_valid, (i > 0));
            end
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ir_in     = enc_i(OP_LW, 5'd0, 5'd9, 16'h0010);
        bus.pc_in     = PW'(32'h400);
        tick();
        checks++;
        if ({bus.out_valid, bus.rd1_en, bus.rd1_addr} !== {1'b0, 1'b1, 5'd9}) begin
            errors++;
            $display("FAIL flush_wait: got v=%b e1=%b a1=%0d want 0 1 9", bus.out_valid, bus.rd1_en, bus.rd1_addr);
        end
        bus.is_flush = 1'b1;
        bus.ir_in    = enc_j(OP_J_TYPE, 26'h0000042);
        bus.pc_in    = PW'(32'h401);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 0", bus.in_ready);
        end
        tick();
        bus.is_flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.ir_out, bus.pc_out, bus.rd1_en, bus.rd2_en} !== '0) begin
            errors++;
            $display("FAIL flush_state: got v=%b ir=%h pc=%h e1=%b e2=%b want all 0",
                     bus.out_valid, bus.ir_out, bus.pc_out, bus.rd1_en, bus.rd2_en);
        end
        bus.rd1_st = 1'b1; bus.rd1_data = 32'h77;
        tick();
        bus.rd1_st = 1'b0;
        checks++;
        if ({bus.out_valid, bus.rd1_en, bus.in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL flush_late_strobe: got v=%b e1=%b rdy=%b want 0 0 1", bus.out_valid, bus.rd1_en, bus.in_ready);
        end
    endtask

    task automatic test_reset_wait();
        bus.in_valid = 1'b1;
        bus.ir_in    = enc_r(OP_SW, 5'd5, 5'd6, 5'd0);
        bus.pc_in    = PW'(32'h700);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.rd1_en, bus.rd2_en, bus.rd1_addr, bus.rd2_addr} !== {2'b11, 5'd5, 5'd6}) begin
            errors++;
            $display("FAIL store_reads: got e1=%b e2=%b a1=%0d a2=%0d want 1 1 5 6",
                     bus.rd1_en, bus.rd2_en, bus.rd1_addr, bus.rd2_addr);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.out_valid, bus.rd1_en, bus.rd2_en, bus.rd1_addr, bus.rd2_addr, bus.in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: got v=%b e1=%b e2=%b a1=%0d a2=%0d rdy=%b want all 0",
                     bus.out_valid, bus.rd1_en, bus.rd2_en, bus.rd1_addr, bus.rd2_addr, bus.in_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

`ifdef ID_BYPASS_EN
    task automatic test_bypass();
        logic [31:0] ir;
        ir = enc_i(OP_LW, 5'd0, 5'd7, 16'h0004);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ir_in     = ir;
        bus.pc_in     = PW'(32'h800);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'hAB;
        push(ir, PW'(32'h800), 32'hAB, 32'h4);
        tick();
        bus.wb_en = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.rd1_en, bus.x_out} !== {1'b1, 1'b0, 32'hAB}) begin
            errors++;
            $display("FAIL bypass_accept: got v=%b e1=%b x=%h want v=1 e1=0 x=ab", bus.out_valid, bus.rd1_en, bus.x_out);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        ir = enc_r(OP_R_TYPE, 5'd0, 5'd1, 5'd2);
        bus.in_valid = 1'b1;
        bus.ir_in    = ir;
        bus.pc_in    = PW'(32'h801);
        push(ir, PW'(32'h801), 32'h11, 32'h55);
        tick();
        bus.in_valid = 1'b0;
        bus.rd1_st = 1'b1; bus.rd1_data = 32'h11;
        bus.rd2_st = 1'b1; bus.rd2_data = 32'h99;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h55;
        tick();
        bus.rd1_st = 1'b0; bus.rd2_st = 1'b0; bus.wb_en = 1'b0;
        checks++;
        if ({bus.out_valid, bus.x_out, bus.y_out} !== {1'b1, 32'h11, 32'h55}) begin
            errors++;
            $display("FAIL bypass_wait: got v=%b x=%h y=%h want v=1 x=11 y=55", bus.out_valid, bus.x_out, bus.y_out);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask
`endif

    task automatic test_halt();
        logic [31:0] ir_h;
        ir_h = enc_j(OP_HALT, 26'h0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ir_in     = ir_h;
        bus.pc_in     = PW'(32'h50);
        tick();
        bus.in_valid = 1'b0;
        bus.is_flush = 1'b1;
        tick();
        bus.is_flush = 1'b0;
        checks++;
        if ({bus.halted, bus.out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL halt_flushed: got halted=%b v=%b want 0 0", bus.halted, bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.pc_in    = PW'(32'h51);
        push(ir_h, PW'(32'h51), 32'h0, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.halted} !== 2'b10) begin
            errors++;
            $display("FAIL halt_full: got v=%b halted=%b want 1 0", bus.out_valid, bus.halted);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ir_in     = enc_j(OP_J_TYPE, 26'h1);
        bus.pc_in     = PW'(32'h52);
        #1;
        checks++;
        if ({bus.halted, bus.out_valid, bus.in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL halt_set: got halted=%b v=%b rdy=%b want 1 0 0", bus.halted, bus.out_valid, bus.in_ready);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL halt_blocks: got v=%b rdy=%b want 0 0", bus.out_valid, bus.in_ready);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.halted, bus.in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL halt_reset: got halted=%b rdy=%b want 0 0", bus.halted, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL halt_release: in_ready got %b want 1", bus.in_ready);
        end
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ir_in     = '0;
        bus.pc_in     = '0;
        bus.out_ready = 1'b0;
        bus.rd1_data  = '0;
        bus.rd1_st    = 1'b0;
        bus.rd2_data  = '0;
        bus.rd2_st    = 1'b0;
        bus.is_flush  = 1'b0;
`ifdef ID_BYPASS_EN
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
`endif
        test_reset();
        test_r_type();
        test_i_type();
        test_j_type();
        test_back_to_back();
        test_flush();
        test_reset_wait();
`ifdef ID_BYPASS_EN
        test_bypass();
`endif
        test_halt();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected bundles never delivered, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
